sprite_mem_server: RTL and testbench

SPRITE_MEM_SERVER -- requirements
Module: sprite_mem_server

---
 rtl/sprite_mem_if.sv | 35 +++
 rtl/sprite_mem_server.sv | 95 +++++++++
 tb/tb_sprite_mem_server.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/sprite_mem_if.sv
// Bundled request/return/memory bus between the sprite memory server and its clients.
// Optional key1/key2 pixel flags exist only when CHROMA_KEY_EN is defined.
interface sprite_mem_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 24
);
    logic              req1, req2;
    logic [ADDR_W-1:0] addr1, addr2;
    logic              ack1, ack2;
    logic [DATA_W-1:0] data1, data2;
    logic              valid1, valid2;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
`ifdef CHROMA_KEY_EN
    logic              key1, key2;
`endif

    modport master (
`ifdef CHROMA_KEY_EN
        input  key1, key2,
`endif
        output req1, req2, addr1, addr2, mem_rdata,
        input  ack1, ack2, data1, data2, valid1, valid2, mem_rd, mem_addr, busy
    );

    modport slave (
`ifdef CHROMA_KEY_EN
        output key1, key2,
`endif
        input  req1, req2, addr1, addr2, mem_rdata,
        output ack1, ack2, data1, data2, valid1, valid2, mem_rd, mem_addr, busy
    );
endinterface

// File: rtl/sprite_mem_server.sv
// Two-port round-robin read server in front of a single-port sprite memory with fixed latency.
// Define CHROMA_KEY_EN to add key1/key2 flags for the FF00FF transparent colour.
module sprite_mem_server #(
    parameter int          ADDR_W  = 19,
    parameter int          DATA_W  = 24,
    parameter int unsigned DEPTH   = 540 * 200,
    parameter int          MEM_LAT = 2          // legal range 1..4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    sprite_mem_if.slave      bus
);
    localparam logic [DATA_W-1:0] KEY_PIX = DATA_W'(24'hFF00FF);

    logic              r_ptr;        // 0: port1 wins next contended cycle
    logic              r_mem_rd;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [MEM_LAT:0]  r_vld_pipe;
    logic [MEM_LAT:0]  r_port_pipe;  // 1 = port2
    logic [MEM_LAT:0]  r_oor_pipe;
    logic [DATA_W-1:0] r_data1, r_data2;
    logic              r_valid1, r_valid2;
`ifdef CHROMA_KEY_EN
    logic              r_key1, r_key2;
`endif

    logic              w_gnt1, w_gnt2, w_gnt, w_oor;
    logic [ADDR_W-1:0] w_gaddr;
    logic [DATA_W-1:0] w_ret;

    assign w_gnt1  = !i_reset && bus.req1 && (!bus.req2 || !r_ptr);
    assign w_gnt2  = !i_reset && bus.req2 && (!bus.req1 ||  r_ptr);
    assign w_gnt   = w_gnt1 || w_gnt2;
    assign w_gaddr = w_gnt2 ? bus.addr2 : bus.addr1;
    assign w_oor   = 32'(w_gaddr) >= DEPTH;
    assign w_ret   = r_oor_pipe[MEM_LAT] ? '0 : bus.mem_rdata;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ptr       <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_addr  <= '0;
            r_vld_pipe  <= '0;
            r_port_pipe <= '0;
            r_oor_pipe  <= '0;
            r_data1     <= '0;
            r_data2     <= '0;
            r_valid1    <= 1'b0;
            r_valid2    <= 1'b0;
`ifdef CHROMA_KEY_EN
            r_key1      <= 1'b0;
            r_key2      <= 1'b0;
`endif
        end else begin
            if (bus.req1 && bus.req2)
                r_ptr <= ~r_ptr;
            r_mem_rd <= w_gnt && !w_oor;
            if (w_gnt && !w_oor)
                r_mem_addr <= w_gaddr;
            // Tag stage MEM_LAT lines up with mem_rdata for its own read.
            r_vld_pipe  <= {r_vld_pipe[MEM_LAT-1:0],  w_gnt};
            r_port_pipe <= {r_port_pipe[MEM_LAT-1:0], w_gnt2};
            r_oor_pipe  <= {r_oor_pipe[MEM_LAT-1:0],  w_oor};
            r_valid1    <= r_vld_pipe[MEM_LAT] && !r_port_pipe[MEM_LAT];
            r_valid2    <= r_vld_pipe[MEM_LAT] &&  r_port_pipe[MEM_LAT];
            if (r_vld_pipe[MEM_LAT] && !r_port_pipe[MEM_LAT]) begin
                r_data1 <= w_ret;
`ifdef CHROMA_KEY_EN
                r_key1  <= w_ret == KEY_PIX;
`endif
            end
            if (r_vld_pipe[MEM_LAT] && r_port_pipe[MEM_LAT]) begin
                r_data2 <= w_ret;
`ifdef CHROMA_KEY_EN
                r_key2  <= w_ret == KEY_PIX;
`endif
            end
        end
    end

    assign bus.ack1     = w_gnt1;
    assign bus.ack2     = w_gnt2;
    assign bus.mem_rd   = r_mem_rd;
    assign bus.mem_addr = r_mem_addr;
    assign bus.data1    = r_data1;
    assign bus.data2    = r_data2;
    assign bus.valid1   = r_valid1;
    assign bus.valid2   = r_valid2;
    // A read counts as in flight until its valid pulse has been delivered.
    assign bus.busy     = (|r_vld_pipe) || r_valid1 || r_valid2;
`ifdef CHROMA_KEY_EN
    assign bus.key1     = r_key1;
    assign bus.key2     = r_key2;
`endif
endmodule

// File: tb/tb_sprite_mem_server.sv
// Directed bench: grant monitor pushes expected returns, return monitor pops and compares.
module tb_sprite_mem_server;
    localparam int          ADDR_W  = 19;
    localparam int          DATA_W  = 24;
    localparam int unsigned DEPTH   = 540 * 200;
    localparam int          MEM_LAT = 2;

    typedef struct packed {
        logic              port2;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb_q[$];
    logic [DATA_W-1:0] rd_pipe [MEM_LAT];

    sprite_mem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sprite_mem_server #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .MEM_LAT(MEM_LAT)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        case (a)
            19'd541: return 24'h123456;
            19'd100: return 24'hFF00FF;
            19'd101: return 24'hFF00FE;
            default: return {a[7:0], ~a[7:0], 8'h3C};
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] exp_word(input logic [ADDR_W-1:0] a);
        return (32'(a) >= DEPTH) ? 24'h000000 : mem_word(a);
    endfunction

    // Memory model: garbage when not read so out-of-range zeroing is visible.
    always @(posedge clk) begin
        rd_pipe[0] <= bus.mem_rd ? mem_word(bus.mem_addr) : 24'hBADBAD;
        for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.mem_rdata = rd_pipe[MEM_LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (bus.ack1 || bus.ack2) chk("ack_exclusive", 32'(bus.ack1 && bus.ack2), 32'd0);
        if (bus.ack1) sb_q.push_back('{port2: 1'b0, data: exp_word(bus.addr1)});
        if (bus.ack2) sb_q.push_back('{port2: 1'b1, data: exp_word(bus.addr2)});
    end

    always @(negedge clk) begin
        exp_t e;
        if (bus.valid1 || bus.valid2) begin
            chk("valid_exclusive", 32'(bus.valid1 && bus.valid2), 32'd0);
            if (sb_q.size() == 0) begin
                chk("unexpected_return", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("ret_port", 32'(bus.valid2), 32'(e.port2));
                chk("ret_data", 32'(bus.valid2 ? bus.data2 : bus.data1), 32'(e.data));
`ifdef CHROMA_KEY_EN
                chk("ret_key", 32'(bus.valid2 ? bus.key2 : bus.key1), 32'(e.data == 24'hFF00FF));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read1(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic key);
        bus.req1 = 1'b1; bus.addr1 = a;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) chk("r1_ack", 32'(bus.ack1), 32'd1);
            chk("r1_valid", 32'(bus.valid1), 32'(k == 4));
            if (k == 4) chk("r1_data", 32'(bus.data1), 32'(d));
`ifdef CHROMA_KEY_EN
            if (k == 4) chk("r1_key", 32'(bus.key1), 32'(key));
`else
            if (k == 4 && key) chk("r1_keyword", 32'(d), 32'h00FF00FF);
`endif
            tick();
            bus.req1 = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req1 = 1'b0; bus.req2 = 1'b0; bus.addr1 = '0; bus.addr2 = '0;
        tick(); tick();
        @(negedge clk);
        chk("rst_ack1", 32'(bus.ack1), 32'd0);
        chk("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_data", 32'({bus.data1, bus.data2} != 0), 32'd0);
        chk("rst_valid", 32'({bus.valid1, bus.valid2}), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        tick(); rst = 1'b0;

        // Single read of word 541
        bus.req1 = 1'b1; bus.addr1 = 19'd541;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) chk("single_ack1", 32'(bus.ack1), 32'd1);
            chk("single_mem_rd", 32'(bus.mem_rd), 32'(k == 1));
            if (k == 1) chk("single_mem_addr", 32'(bus.mem_addr), 32'd541);
            chk("single_valid1", 32'(bus.valid1), 32'(k == 4));
            chk("single_valid2", 32'(bus.valid2), 32'd0);
            if (k == 4) chk("single_data1", 32'(bus.data1), 32'h123456);
            tick();
            bus.req1 = 1'b0;
        end

        // Contention: alternating 1,2,1,2
        bus.addr1 = 19'd10; bus.addr2 = 19'd20;
        for (int k = 0; k < 10; k++) begin
            bus.req1 = (k < 4); bus.req2 = (k < 4);
            @(negedge clk);
            if (k < 4) begin
                chk("cont_ack1", 32'(bus.ack1), 32'(k % 2 == 0));
                chk("cont_ack2", 32'(bus.ack2), 32'(k % 2 == 1));
            end
            chk("cont_valid1", 32'(bus.valid1), 32'(k == 4 || k == 6));
            chk("cont_valid2", 32'(bus.valid2), 32'(k == 5 || k == 7));
            if (k == 6) chk("cont_data1", 32'(bus.data1), 32'h0AF53C);
            if (k == 7) chk("cont_data2", 32'(bus.data2), 32'h14EB3C);
            tick();
        end
        bus.req1 = 1'b0; bus.req2 = 1'b0;

        // Out of range on port 2
        bus.req2 = 1'b1; bus.addr2 = 19'(DEPTH);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) chk("oor_ack2", 32'(bus.ack2), 32'd1);
            chk("oor_mem_rd", 32'(bus.mem_rd), 32'd0);
            chk("oor_valid2", 32'(bus.valid2), 32'(k == 4));
            if (k == 4) chk("oor_data2", 32'(bus.data2), 32'h000000);
            tick();
            bus.req2 = 1'b0;
        end

        // Streaming addresses 0..7 on port 1
        for (int k = 0; k < 13; k++) begin
            bus.req1 = (k < 8); bus.addr1 = 19'(k);
            @(negedge clk);
            chk("strm_ack1", 32'(bus.ack1), 32'(k < 8));
            chk("strm_mem_rd", 32'(bus.mem_rd), 32'(k >= 1 && k <= 8));
            if (k >= 1 && k <= 8) chk("strm_mem_addr", 32'(bus.mem_addr), 32'(k - 1));
            chk("strm_valid1", 32'(bus.valid1), 32'(k >= 4 && k <= 11));
            chk("strm_busy", 32'(bus.busy), 32'(k >= 1 && k <= 11));
            if (k == 11) chk("strm_last", 32'(bus.data1), 32'h07F83C);
            tick();
        end
        bus.req1 = 1'b0;

        // Chroma key words
        read1(19'd100, 24'hFF00FF, 1'b1);
        read1(19'd101, 24'hFF00FE, 1'b0);

        // Reset mid-flight with the pointer left on port 2
        for (int k = 0; k < 3; k++) begin
            bus.req1 = (k != 1); bus.req2 = (k < 2);
            bus.addr1 = 19'(30 + k); bus.addr2 = 19'd31;
            rst = (k == 2);
            @(negedge clk);
            chk("rmf_ack1", 32'(bus.ack1), 32'(k == 0));
            chk("rmf_ack2", 32'(bus.ack2), 32'(k == 1));
            tick();
        end
        rst = 1'b0; bus.req1 = 1'b0; bus.req2 = 1'b0;
        sb_q.delete();
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk("rmf_valid", 32'({bus.valid1, bus.valid2}), 32'd0);
            chk("rmf_busy", 32'(bus.busy), 32'd0);
            chk("rmf_mem_rd", 32'(bus.mem_rd), 32'd0);
            tick();
        end
        bus.req1 = 1'b1; bus.req2 = 1'b1; bus.addr1 = 19'd40; bus.addr2 = 19'd41;
        @(negedge clk);
        chk("rmf_ptr_ack1", 32'(bus.ack1), 32'd1);
        chk("rmf_ptr_ack2", 32'(bus.ack2), 32'd0);
        tick();
        bus.req1 = 1'b0;
        @(negedge clk);
        chk("rmf_tail_ack2", 32'(bus.ack2), 32'd1);
        tick();
        bus.req2 = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
